user_io_spi_master: RTL and testbench
=====================================

// Module: user_io_spi_master
// PURPOSE
// SPI master for the IO-controller side of the user_io command link. Issues one command
// transaction (command byte + N payload bytes) to the core's user_io slave and returns every
// byte shifted back on MISO (byte 0 = core type). Used where the FPGA itself must drive the
// link, e.g. self-hosted boot logic, and as the bus-functional master in user_io benches.
// PARAMETERS
// CLK_DIV  4  clk_sys cycles per SPI_CLK half-period; legal range 2..255
// PORTS
// clk_sys      in   1   system clock; all logic on posedge
// reset_n      in   1   asynchronous active-low reset
// start        in   1   1-cycle request; sampled only when busy=0
// cmd          in   8   command byte, captured on accepted start
// len          in   10  payload byte count after cmd (0..1023), captured on accepted start
// tx_req       out  1   1-cycle pulse: supply next payload byte
// tx_data      in   8   payload byte; sampled on the cycle after tx_req
// rx_valid     out  1   1-cycle pulse: rx_data/rx_idx valid
// rx_data      out  8   byte received on MISO
// rx_idx       out  10  index of received byte (0 = byte shifted during cmd)
// busy         out  1   high from accepted start until done
// done         out  1   1-cycle pulse at end of transaction
// SPI_SS_IO    out  1   slave select, active low
// SPI_CLK      out  1   SPI clock, idle low
// SPI_MOSI     out  1   serial data to slave, MSB first
// SPI_MISO     in   1   serial data from slave
// BEHAVIOUR
// - Reset (async, any state): SPI_SS_IO=1, SPI_CLK=0, SPI_MOSI=0, busy=0, done=0, tx_req=0,
//   rx_valid=0, rx_data=0, rx_idx=0, FSM=IDLE. Mid-transaction reset aborts immediately; no done.
// - Mode 0: MOSI changes only while SPI_CLK low; slave samples MOSI on rise, drives MISO on fall;
//   master samples MISO on the clk_sys edge that drives SPI_CLK 0->1.
// - FSM: IDLE -> SETUP -> LOW <-> HIGH -> TAIL -> GAP -> IDLE.
//   IDLE: start & !busy -> latch cmd/len, shift_reg=cmd, busy=1, SS=0, MOSI=cmd[7] -> SETUP.
//   SETUP: hold CLK_DIV cycles -> HIGH (SPI_CLK=1, sample MISO).
//   HIGH: hold CLK_DIV; then SPI_CLK=0; if bits remain in byte, MOSI=next bit -> LOW;
//     byte done and bytes remain -> MOSI=next byte MSB -> LOW; last bit of last byte -> TAIL.
//   LOW: hold CLK_DIV -> SPI_CLK=1, sample MISO -> HIGH.
//   TAIL: SPI_CLK=0 held CLK_DIV cycles -> SS=1, MOSI=0 -> GAP.
//   GAP: SS high 2*CLK_DIV cycles (lets slave resync transfer end) -> done=1, busy=0 -> IDLE.
// - Total bytes = len+1. Bit counter 3b wraps 7->0; byte counter 10b counts 0..len, no wrap.
// - tx_req: pulsed on the rising SPI_CLK edge of bit 0 (LSB) of byte k when byte k+1 is payload
//   (k < len); tx_data captured next cycle into a hold register, loaded at byte boundary.
//   len=0: tx_req never asserts.
// - rx: 8th MISO sample of byte k completes it; rx_valid pulses the following cycle with
//   rx_data=byte, rx_idx=k. Exactly len+1 rx_valid pulses per transaction.
// - start while busy ignored (not queued). start and done same cycle: start ignored.
// - Transaction duration from start accept to done: CLK_DIV*(1+16*(len+1)-1+1+2) + 1 cycles;
//   exact count checked in bench.
// - SPI_CLK duty 50%, period 2*CLK_DIV clk_sys cycles; no glitches (all SPI outputs registered).
// TESTING
// - Reset: reset_n=0 -> SS=1, CLK=0, MOSI=0, busy=0, all pulses 0; release -> unchanged until start.
// - cmd=0x05, len=1, tx_data=0x15, CLK_DIV=4 -> MOSI bits 00000101 00010101 at rising edges;
//   16 SPI_CLK pulses; one tx_req; done once.
// - user_io slave model returning 0xA6 then 0x3C, cmd=0x04 len=1 -> rx_valid idx0=0xA6,
//   idx1=0x3C.
// - len=0, cmd=0x01 -> 8 clocks, no tx_req, one rx_valid (idx0), SS low exactly during transfer.
// - start pulsed while busy -> ignored; second start after done -> new transaction, rx_idx restarts 0.
// - reset_n low during byte 1 bit 3 -> SS=1, CLK=0 within same cycle, no done; next start clean.

Source files
------------

// File: rtl/user_io_spi_master_if.sv
// Host-side bundle for user_io_spi_master: start/cmd/len request,
// tx_req/tx_data payload pull, rx_valid/rx_data/rx_idx return, busy/done.
interface user_io_spi_master_if;
  logic       start;
  logic [7:0] cmd;
  logic [9:0] len;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [9:0] rx_idx;
  logic       busy;
  logic       done;

  modport master (
    output start, cmd, len, tx_data,
    input  tx_req, rx_valid, rx_data, rx_idx,
    input  busy, done
  );

  modport slave (
    input  start, cmd, len, tx_data,
    output tx_req, rx_valid, rx_data, rx_idx,
    output busy, done
  );
endinterface

// File: rtl/user_io_spi_master.sv
// Mode-0 SPI master issuing one user_io command (cmd + len payload bytes).
// Ports: clk_sys, reset_n, bus (host bundle), SPI_SS_IO/CLK/MOSI/MISO pins.
module user_io_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  user_io_spi_master_if.slave bus,
  output logic SPI_SS_IO,
  output logic SPI_CLK,
  output logic SPI_MOSI,
  input  logic SPI_MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_TAIL,
    S_GAP
  } state_t;

  localparam logic [8:0] LP_HALF = 9'(CLK_DIV - 1);
  localparam logic [8:0] LP_GAP  = 9'(2 * CLK_DIV - 1);

  state_t     r_state, w_state;
  logic [8:0] r_cnt,   w_cnt;
  logic [2:0] r_bit,   w_bit;
  logic [9:0] r_byte,  w_byte;
  logic [9:0] r_len,   w_len;
  logic [7:0] r_sh,    w_sh;
  logic [7:0] r_rsh,   w_rsh;
  logic [7:0] r_hold,  w_hold;
  logic       r_txd,   w_txd;
  logic       r_ss,    w_ss;
  logic       r_sclk,  w_sclk;
  logic       r_mosi,  w_mosi;
  logic       r_busy,  w_busy;
  logic       r_done,  w_done;
  logic       r_txreq, w_txreq;
  logic       r_rxv,   w_rxv;
  logic [7:0] r_rxd,   w_rxd;
  logic [9:0] r_rxi,   w_rxi;

  logic [8:0] w_lim;
  logic       w_hit;
  logic [7:0] w_nxt;
  logic [7:0] w_rbyte;

  assign w_lim   = (r_state == S_GAP) ? LP_GAP : LP_HALF;
  assign w_hit   = (r_cnt == w_lim);
  // tx_data may land on the same edge as the byte boundary
  assign w_nxt   = r_txd ? bus.tx_data : r_hold;
  assign w_rbyte = {r_rsh[6:0], SPI_MISO};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_len   <= '0;
      r_sh    <= '0;
      r_rsh   <= '0;
      r_hold  <= '0;
      r_txd   <= 1'b0;
      r_ss    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_txreq <= 1'b0;
      r_rxv   <= 1'b0;
      r_rxd   <= '0;
      r_rxi   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_byte  <= w_byte;
      r_len   <= w_len;
      r_sh    <= w_sh;
      r_rsh   <= w_rsh;
      r_hold  <= w_hold;
      r_txd   <= w_txd;
      r_ss    <= w_ss;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_txreq <= w_txreq;
      r_rxv   <= w_rxv;
      r_rxd   <= w_rxd;
      r_rxi   <= w_rxi;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = w_hit ? 9'd0 : r_cnt + 9'd1;
    w_bit   = r_bit;
    w_byte  = r_byte;
    w_len   = r_len;
    w_sh    = r_sh;
    w_rsh   = r_rsh;
    w_hold  = w_nxt;
    w_txd   = r_txreq;
    w_ss    = r_ss;
    w_sclk  = r_sclk;
    w_mosi  = r_mosi;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_txreq = 1'b0;
    w_rxv   = 1'b0;
    w_rxd   = r_rxd;
    w_rxi   = r_rxi;
    unique case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        // done cycle still blocks a new start
        if (bus.start && !r_busy && !r_done) begin
          w_len   = bus.len;
          w_sh    = bus.cmd;
          w_mosi  = bus.cmd[7];
          w_ss    = 1'b0;
          w_busy  = 1'b1;
          w_bit   = '0;
          w_byte  = '0;
          w_state = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (w_hit) begin
          w_sclk  = 1'b1;
          w_rsh   = w_rbyte;
          w_state = S_HIGH;
          if (r_bit == 3'd7) begin
            w_rxv = 1'b1;
            w_rxd = w_rbyte;
            w_rxi = r_byte;
            if (r_byte != r_len) w_txreq = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (w_hit) begin
          w_sclk = 1'b0;
          w_bit  = r_bit + 3'd1;
          if (r_bit != 3'd7) begin
            w_sh    = {r_sh[6:0], 1'b0};
            w_mosi  = r_sh[6];
            w_state = S_LOW;
          end else if (r_byte != r_len) begin
            w_sh    = w_nxt;
            w_mosi  = w_nxt[7];
            w_byte  = r_byte + 10'd1;
            w_state = S_LOW;
          end else begin
            w_state = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (w_hit) begin
          w_ss    = 1'b1;
          w_mosi  = 1'b0;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (w_hit) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign SPI_SS_IO    = r_ss;
  assign SPI_CLK      = r_sclk;
  assign SPI_MOSI     = r_mosi;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tx_req   = r_txreq;
  assign bus.rx_valid = r_rxv;
  assign bus.rx_data  = r_rxd;
  assign bus.rx_idx   = r_rxi;

endmodule

// File: tb/tb_user_io_spi_master.sv
// Scoreboard bench for user_io_spi_master with a mode-0 user_io slave model.
// Directed transactions push expected MOSI/rx bytes; a negedge monitor pops them.
module tb_user_io_spi_master;
  localparam int D = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic SPI_SS_IO, SPI_CLK, SPI_MOSI;
  logic SPI_MISO = 1'b0;

  user_io_spi_master_if bus();

  user_io_spi_master #(.CLK_DIV(D)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bus      (bus),
    .SPI_SS_IO(SPI_SS_IO),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO)
  );

  always #5 clk_sys = ~clk_sys;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event not expected or bound expired", nm);
  endtask

  logic [7:0]  exp_mosi[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  sl_q[$];
  logic [17:0] exp_rx[$];

  int n_rise = 0, n_txreq = 0, n_done = 0, n_rxv = 0, sl_cnt = 0;
  logic [7:0]  sl_out = '0, sl_in = '0, em = '0;
  logic [17:0] er = '0;
  logic p_ss = 1'b1, p_clk = 1'b0;

  always @(negedge clk_sys) begin
    if (!reset_n) bus.tx_data = '0;
    if (bus.rx_valid) begin
      n_rxv++;
      if (exp_rx.size() == 0) fail("rx_unexpected");
      else begin
        er = exp_rx.pop_front();
        chk("rx_idx_data", {14'd0, bus.rx_idx, bus.rx_data}, {14'd0, er});
      end
    end
    if (bus.tx_req) begin
      n_txreq++;
      if (tx_q.size() == 0) fail("tx_req_unexpected");
      else bus.tx_data = tx_q.pop_front();
    end
    if (bus.done) n_done++;
    if (p_ss && !SPI_SS_IO) begin
      sl_cnt   = 0;
      sl_out   = (sl_q.size() != 0) ? sl_q.pop_front() : 8'h00;
      SPI_MISO = sl_out[7];
    end
    if (!p_clk && SPI_CLK) begin
      n_rise++;
      chk("ss_low_at_rise", {31'd0, SPI_SS_IO}, 32'd0);
    end
    if (!SPI_SS_IO) begin
      if (!p_clk && SPI_CLK) begin
        sl_in = {sl_in[6:0], SPI_MOSI};
        sl_cnt++;
        if (sl_cnt == 8) begin
          if (exp_mosi.size() == 0) fail("mosi_unexpected");
          else begin
            em = exp_mosi.pop_front();
            chk("mosi_byte", {24'd0, sl_in}, {24'd0, em});
          end
        end
      end
      if (p_clk && !SPI_CLK) begin
        if (sl_cnt == 8) begin
          sl_cnt   = 0;
          sl_out   = (sl_q.size() != 0) ? sl_q.pop_front() : 8'h00;
          SPI_MISO = sl_out[7];
        end else begin
          SPI_MISO = sl_out[7 - sl_cnt];
        end
      end
    end
    p_ss  = SPI_SS_IO;
    p_clk = SPI_CLK;
  end

  task automatic arm(input logic [7:0] c, input int l,
                     input logic [7:0] p0, input logic [7:0] p1,
                     input logic [7:0] r0, input logic [7:0] r1,
                     input logic [7:0] r2);
    logic [7:0] p [0:1];
    logic [7:0] r [0:2];
    p[0] = p0; p[1] = p1;
    r[0] = r0; r[1] = r1; r[2] = r2;
    exp_mosi.push_back(c);
    for (int i = 0; i < l; i++) begin
      exp_mosi.push_back(p[i]);
      tx_q.push_back(p[i]);
    end
    for (int i = 0; i <= l; i++) begin
      sl_q.push_back(r[i]);
      exp_rx.push_back({10'(i), r[i]});
    end
  endtask

  task automatic run(input logic [7:0] c, input int l, input int poke);
    int n, r0, t0, d0, v0;
    r0 = n_rise; t0 = n_txreq; d0 = n_done; v0 = n_rxv;
    @(negedge clk_sys);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.len   = 10'(l);
    @(posedge clk_sys);
    #1;
    bus.start = 1'b0;
    bus.cmd   = ~c;
    bus.len   = 10'd0;
    chk("busy_on_accept", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (n < 20000) begin
      @(posedge clk_sys);
      n++;
      #1;
      bus.start = (poke != 0 && n == poke);
      if (bus.done) break;
    end
    if (!bus.done) fail("done_timeout");
    chk("duration", n + 1, D * (1 + 16 * (l + 1) - 1 + 1 + 2) + 1);
    bus.cmd   = 8'hEE;
    bus.start = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.start = 1'b0;
    chk("start_at_done_ignored", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("sclk_rises", n_rise - r0, 8 * (l + 1));
    chk("tx_req_count", n_txreq - t0, l);
    chk("done_count", n_done - d0, 1);
    chk("rx_valid_count", n_rxv - v0, l + 1);
    chk("ss_idle", {29'd0, SPI_SS_IO, SPI_CLK, SPI_MOSI}, 32'd4);
    chk("queues_empty", exp_rx.size() + exp_mosi.size() + tx_q.size(), 0);
  endtask

  initial begin
    int k, d0, r0;
    bus.start = 1'b0;
    bus.cmd   = '0;
    bus.len   = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_pins", {29'd0, SPI_SS_IO, SPI_CLK, SPI_MOSI}, 32'd4);
    chk("rst_flags", {28'd0, bus.busy, bus.done, bus.tx_req, bus.rx_valid}, 0);
    chk("rst_rx", {14'd0, bus.rx_idx, bus.rx_data}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("idle_pins", {29'd0, SPI_SS_IO, SPI_CLK, SPI_MOSI}, 32'd4);
    chk("idle_busy", {31'd0, bus.busy}, 0);

    arm(8'h05, 1, 8'h15, 8'h00, 8'h12, 8'h34, 8'h00);
    run(8'h05, 1, 0);

    arm(8'h04, 1, 8'h5A, 8'h00, 8'hA6, 8'h3C, 8'h00);
    run(8'h04, 1, 0);

    arm(8'h01, 0, 8'h00, 8'h00, 8'hA6, 8'h00, 8'h00);
    run(8'h01, 0, 0);

    arm(8'h10, 2, 8'h81, 8'h7E, 8'h55, 8'hC3, 8'h0F);
    run(8'h10, 2, 50);

    arm(8'h22, 0, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
    run(8'h22, 0, 0);

    // abort during byte 1, bit 3
    arm(8'h04, 1, 8'h99, 8'h00, 8'hA6, 8'h77, 8'h00);
    d0 = n_done;
    r0 = n_rise;
    @(negedge clk_sys);
    bus.cmd   = 8'h04;
    bus.len   = 10'd1;
    bus.start = 1'b1;
    @(negedge clk_sys);
    bus.start = 1'b0;
    k = 0;
    while (n_rise < r0 + 12 && k < 5000) begin
      @(posedge clk_sys);
      k++;
    end
    if (k >= 5000) fail("abort_wait");
    #2;
    chk("pre_abort_sclk", {31'd0, SPI_CLK}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_pins", {30'd0, SPI_SS_IO, SPI_CLK}, 32'd2);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    repeat (4) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk_sys);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_left", exp_mosi.size(), 1);
    exp_mosi.delete();
    exp_rx.delete();
    tx_q.delete();
    sl_q.delete();

    arm(8'h05, 1, 8'h15, 8'h00, 8'hA6, 8'h3C, 8'h00);
    run(8'h05, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
